// File: rtl/sonar_proximity_frontend.sv
// sonar_proximity_frontend
// Round-robin ultrasonic ranging front-end for three HC-SR04-style sensors.
// Fires a trigger on one channel, times the echo pulse, and turns the width
// into a registered "object close" flag using a near threshold plus hysteresis.
//
// Build option:
//   SONAR_CONFIRM_EN - when defined, a near flag only flips after two
//                      consecutive measurements on that channel agree on the
//                      change. When undefined, the first qualifying
//                      measurement flips it.

module sonar_proximity_frontend #(
  parameter int TRIG_LEN     = 10,
  parameter int RISE_TIMEOUT = 4000,
  parameter int ECHO_TIMEOUT = 30000,
  parameter int NEAR_THRESH  = 5800,
  parameter int HYST         = 290,
  parameter int GAP_CYCLES   = 2000,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] echo_in,
  output logic [2:0] trig_out,
  output logic [2:0] near,
  output logic       meas_done,
  output logic [1:0] meas_chan
);

  // Sequencer states
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_TRIG      = 3'd1;
  localparam logic [2:0] S_WAIT_RISE = 3'd2;
  localparam logic [2:0] S_MEASURE   = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_GAP       = 3'd5;

  // Counter-width copies of the timing parameters
  localparam logic [CNT_W-1:0] TRIG_LEN_C     = CNT_W'(TRIG_LEN);
  localparam logic [CNT_W-1:0] RISE_TIMEOUT_C = CNT_W'(RISE_TIMEOUT);
  localparam logic [CNT_W-1:0] ECHO_TIMEOUT_C = CNT_W'(ECHO_TIMEOUT);
  localparam logic [CNT_W-1:0] NEAR_THRESH_C  = CNT_W'(NEAR_THRESH);
  localparam logic [CNT_W-1:0] RELEASE_C      = CNT_W'(NEAR_THRESH + HYST);
  localparam logic [CNT_W-1:0] GAP_CYCLES_C   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  // Echo synchronisers
  logic [2:0] sync_meta_reg;
  logic [2:0] e_s_reg;

  // Sequencer state
  logic [2:0]       state_reg;
  logic [1:0]       ch_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       trig_reg;
  logic             meas_done_reg;
  logic [2:0]       near_reg;
  logic [2:0]       near_next;

  // Derived combinational terms
  logic             e_sel;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       ch_after;
  logic             fin_valid;
  logic             fin_far;
  logic             want_set;
  logic             want_clr;
  logic             change;

  // One-hot trigger pattern for a channel number
  function automatic logic [2:0] ch_onehot(input logic [1:0] c);
    ch_onehot = 3'b001 << c;
  endfunction

  assign e_sel    = e_s_reg[ch_reg];
  assign cnt_inc  = cnt_reg + CNT_ONE;
  assign ch_after = (ch_reg == 2'd2) ? 2'd0 : ch_reg + 2'd1;

  // Two-flop synchroniser on every echo line; keeps running while ena is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta_reg <= 3'b000;
      e_s_reg       <= 3'b000;
    end else begin
      sync_meta_reg <= echo_in;
      e_s_reg       <= sync_meta_reg;
    end
  end

  // Detect the cycle in which a measurement finishes and classify the result.
  // In MEASURE the counter holds the echo width seen so far; a falling edge
  // finishes with that width, either timeout finishes as FAR.
  always_comb begin
    fin_valid = 1'b0;
    fin_far   = 1'b0;
    case (state_reg)
      S_WAIT_RISE: begin
        if (!e_sel && (cnt_inc == RISE_TIMEOUT_C)) begin
          fin_valid = 1'b1;
          fin_far   = 1'b1;
        end
      end
      S_MEASURE: begin
        if (e_sel) begin
          if (cnt_inc == ECHO_TIMEOUT_C) begin
            fin_valid = 1'b1;
            fin_far   = 1'b1;
          end
        end else begin
          fin_valid = 1'b1;
          fin_far   = 1'b0;
        end
      end
      default: begin
        fin_valid = 1'b0;
        fin_far   = 1'b0;
      end
    endcase
  end

  // Hysteresis decision for the selected channel: does this result ask to
  // flip its near flag? Width equal to the threshold is not near; width equal
  // to threshold plus hysteresis releases.
  always_comb begin
    want_set = !fin_far && (cnt_reg < NEAR_THRESH_C);
    want_clr = fin_far || (cnt_reg >= RELEASE_C);
    change   = fin_valid && (near_reg[ch_reg] ? want_clr : want_set);
  end

  // Main measurement sequencer: trigger, wait for echo, time it, settle
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      state_reg     <= S_IDLE;
      ch_reg        <= 2'd0;
      cnt_reg       <= '0;
      trig_reg      <= 3'b000;
      meas_done_reg <= 1'b0;
    end else begin
      meas_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          state_reg <= S_TRIG;
          cnt_reg   <= '0;
          trig_reg  <= ch_onehot(ch_reg);
        end
        S_TRIG: begin
          if (cnt_inc == TRIG_LEN_C) begin
            trig_reg  <= 3'b000;
            cnt_reg   <= '0;
            state_reg <= S_WAIT_RISE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        S_WAIT_RISE: begin
          if (e_sel) begin
            cnt_reg   <= CNT_ONE;
            state_reg <= S_MEASURE;
          end else if (fin_valid) begin
            cnt_reg       <= '0;
            meas_done_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        S_MEASURE: begin
          if (fin_valid) begin
            cnt_reg       <= '0;
            meas_done_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        S_DONE: begin
          cnt_reg   <= '0;
          state_reg <= S_GAP;
        end
        S_GAP: begin
          if (cnt_inc == GAP_CYCLES_C) begin
            cnt_reg   <= '0;
            ch_reg    <= ch_after;
            trig_reg  <= ch_onehot(ch_after);
            state_reg <= S_TRIG;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          cnt_reg   <= '0;
          trig_reg  <= 3'b000;
        end
      endcase
    end
  end

`ifdef SONAR_CONFIRM_EN
  // A change only lands when the previous measurement on the same channel
  // asked for it too; the pending flag remembers that first request.
  logic [2:0] pend_reg;
  logic [2:0] pend_next;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic sel;
    assign sel           = fin_valid && (ch_reg == 2'(gi));
    assign near_next[gi] = (sel && change && pend_reg[gi]) ? ~near_reg[gi] : near_reg[gi];
    assign pend_next[gi] = sel ? (change && !pend_reg[gi]) : pend_reg[gi];
  end

  // Near and pending flags update on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      near_reg <= 3'b000;
      pend_reg <= 3'b000;
    end else begin
      near_reg <= near_next;
      pend_reg <= pend_next;
    end
  end
`else
  // The first qualifying measurement flips the channel's flag
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic sel;
    assign sel           = fin_valid && (ch_reg == 2'(gi));
    assign near_next[gi] = (sel && change) ? ~near_reg[gi] : near_reg[gi];
  end

  // Near flags update on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (!rst_n || !ena) begin
      near_reg <= 3'b000;
    end else begin
      near_reg <= near_next;
    end
  end
`endif

  assign trig_out  = trig_reg;
  assign near      = near_reg;
  assign meas_done = meas_done_reg;
  assign meas_chan = ch_reg;

endmodule

// File: tb/tb_sonar_proximity_frontend.sv
// Testbench for sonar_proximity_frontend: a scripted table of echo widths
// with expected near flags, hand-written enable/reset sequences, then
// randomized echoes checked against a measurement-level reference model.

module tb_sonar_proximity_frontend;

  localparam int TRIG_LEN     = 4;
  localparam int RISE_TIMEOUT = 200;
  localparam int ECHO_TIMEOUT = 500;
  localparam int NEAR_THRESH  = 100;
  localparam int HYST         = 20;
  localparam int GAP_CYCLES   = 10;
  localparam int CNT_W        = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [2:0] echo_in = 3'b000;
  logic [2:0] trig_out;
  logic [2:0] near;
  logic       meas_done;
  logic [1:0] meas_chan;

  sonar_proximity_frontend #(
    .TRIG_LEN(TRIG_LEN), .RISE_TIMEOUT(RISE_TIMEOUT), .ECHO_TIMEOUT(ECHO_TIMEOUT),
    .NEAR_THRESH(NEAR_THRESH), .HYST(HYST), .GAP_CYCLES(GAP_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .echo_in(echo_in),
    .trig_out(trig_out), .near(near), .meas_done(meas_done), .meas_chan(meas_chan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: near flags, next channel, gap tracking
  logic [2:0] m_near = 3'b000;
`ifdef SONAR_CONFIRM_EN
  logic [2:0] m_pend = 3'b000;
`endif
  int m_ch = 0;
  bit gap_valid = 0;

  typedef struct {
    int         w;        // echo width in cycles; 0 = no echo
    int         dly;      // cycles after trigger end before echo rises
    logic [2:0] exp_def;  // near after this measurement, default build
    logic [2:0] exp_cf;   // near after this measurement, confirm build
  } vec_t;

  vec_t tab[19];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Apply one measurement result to the model, straight from the hysteresis rules
  task automatic model_meas(input int ch, input int w);
    bit far;
    bit want;
    far = (w == 0) || (w >= ECHO_TIMEOUT);
    if (m_near[ch]) want = far || (w >= NEAR_THRESH + HYST);
    else            want = !far && (w < NEAR_THRESH);
`ifdef SONAR_CONFIRM_EN
    if (!want) m_pend[ch] = 1'b0;
    else if (m_pend[ch]) begin
      m_near[ch] = ~m_near[ch];
      m_pend[ch] = 1'b0;
    end else m_pend[ch] = 1'b1;
`else
    if (want) m_near[ch] = ~m_near[ch];
`endif
  endtask

  // Run one complete measurement on the expected channel and check it
  task automatic do_meas(input int idx, input int w, input int dly, input bit noise,
                         input bit use_tab, input logic [2:0] exp_tab);
    int cyc;
    int len;
    int lat;
    bit done;
    int ch;
    logic [2:0] exp_near;
    ch = m_ch;
    cyc = gap_valid ? 1 : 0;
    while (trig_out == 3'b000 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    chk($sformatf("m%0d trig_sel", idx), trig_out, 1 << ch);
    if (trig_out == 3'b000) return;
    if (gap_valid) chk($sformatf("m%0d gap", idx), cyc, GAP_CYCLES + 1);
    len = 0;
    while (trig_out != 3'b000 && len < 1000) begin
      len++; @(posedge clk); #1;
    end
    chk($sformatf("m%0d trig_len", idx), len, TRIG_LEN);
    cyc = 0;
    done = 0;
    while (!done && cyc < 3000) begin
      if (w > 0 && cyc == dly) echo_in[ch] = 1'b1;
      if (w > 0 && cyc == dly + w) echo_in[ch] = 1'b0;
      if (noise) for (int k = 0; k < 3; k++) if (k != ch) echo_in[k] = 1'($urandom_range(0, 1));
      @(posedge clk); #1; cyc++;
      if (meas_done) done = 1;
    end
    echo_in = 3'b000;
    chk($sformatf("m%0d done_seen", idx), int'(done), 1);
    if (!done) return;
    // Two synchroniser flops plus the sampling edge delay the echo by 3 cycles
    if (w == 0) lat = RISE_TIMEOUT;
    else if (w >= ECHO_TIMEOUT) lat = dly + ECHO_TIMEOUT + 2;
    else lat = dly + w + 3;
    chk($sformatf("m%0d latency", idx), cyc, lat);
    model_meas(ch, w);
    exp_near = use_tab ? exp_tab : m_near;
    chk($sformatf("m%0d near", idx), near, exp_near);
    chk($sformatf("m%0d meas_chan", idx), meas_chan, ch);
    $display("meas %0d: ch=%0d width=%0d delay=%0d near=%b", idx, ch, w, dly, near);
    @(posedge clk); #1;
    chk($sformatf("m%0d done_pulse", idx), meas_done, 0);
    gap_valid = 1;
    m_ch = (ch == 2) ? 0 : ch + 1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    int r;
    tab[0]  = '{60,  5, 3'b001, 3'b000};
    tab[1]  = '{0,   0, 3'b001, 3'b000};
    tab[2]  = '{600, 3, 3'b001, 3'b000};
    tab[3]  = '{60,  8, 3'b001, 3'b001};
    tab[4]  = '{30,  0, 3'b011, 3'b001};
    tab[5]  = '{100, 4, 3'b011, 3'b001};
    tab[6]  = '{110, 2, 3'b011, 3'b001};
    tab[7]  = '{30,  6, 3'b011, 3'b011};
    tab[8]  = '{99,  1, 3'b111, 3'b011};
    tab[9]  = '{120, 0, 3'b110, 3'b011};
    tab[10] = '{119, 7, 3'b110, 3'b011};
    tab[11] = '{600, 2, 3'b010, 3'b011};
    tab[12] = '{100, 3, 3'b010, 3'b011};
    tab[13] = '{0,   0, 3'b000, 3'b011};
    tab[14] = '{0,   0, 3'b000, 3'b011};
    tab[15] = '{50,  4, 3'b001, 3'b011};
    tab[16] = '{50,  2, 3'b011, 3'b011};
    tab[17] = '{200, 5, 3'b011, 3'b011};
    tab[18] = '{80,  3, 3'b011, 3'b011};

    // Reset state
    ena = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset trig_out", trig_out, 0);
    chk("reset near", near, 0);
    chk("reset meas_done", meas_done, 0);
    chk("reset meas_chan", meas_chan, 0);
    rst_n = 1'b1;

    // Scripted measurements
    for (int i = 0; i < 19; i++) begin
`ifdef SONAR_CONFIRM_EN
      do_meas(i, tab[i].w, tab[i].dly, 1'b0, 1'b1, tab[i].exp_cf);
`else
      do_meas(i, tab[i].w, tab[i].dly, 1'b0, 1'b1, tab[i].exp_def);
`endif
    end

    // Drop ena while channel 1 is mid-echo
    cyc = 1;
    while (trig_out == 3'b000 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("ena_seq trig_sel", trig_out, 1 << m_ch);
    cyc = 0;
    while (trig_out != 3'b000 && cyc < 1000) begin
      @(posedge clk); #1; cyc++;
    end
    echo_in[m_ch] = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("ena_seq near_before", near, m_near);
    ena = 1'b0;
    @(posedge clk); #1;
    chk("ena_seq near", near, 0);
    chk("ena_seq trig_out", trig_out, 0);
    chk("ena_seq meas_done", meas_done, 0);
    chk("ena_seq meas_chan", meas_chan, 0);
    $display("ena drop during measure on ch=%0d: near=%b trig_out=%b", m_ch, near, trig_out);
    echo_in = 3'b000;
    m_near = 3'b000;
`ifdef SONAR_CONFIRM_EN
    m_pend = 3'b000;
`endif
    m_ch = 0;
    gap_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    ena = 1'b1;

    // Randomized measurements against the model, with noise on idle channels
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) w = 0;
      else if (r == 1) w = $urandom_range(490, 520);
      else if (r <= 3) w = $urandom_range(95, 125);
      else w = $urandom_range(1, 200);
      do_meas(100 + i, w, $urandom_range(0, 60), 1'($urandom_range(0, 1)), 1'b0, 3'b000);
    end

    // Reset in the middle of a trigger pulse
    cyc = 1;
    while (trig_out == 3'b000 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
    end
    chk("rst_trig trig_sel", trig_out, 1 << m_ch);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_trig trig_out", trig_out, 0);
    chk("rst_trig near", near, 0);
    chk("rst_trig meas_done", meas_done, 0);
    chk("rst_trig meas_chan", meas_chan, 0);
    $display("reset during trigger: trig_out=%b near=%b", trig_out, near);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
